// File: rtl/top_pkg.sv
// Shared constants for the Pmod JC SPI register bridge: chip ID, register
// addresses and the command FSM state type.
package top_pkg;

  localparam logic [7:0] CHIP_ID = 8'h07;

  localparam logic [6:0] ADDR_CHIP_ID = 7'h00;
  localparam logic [6:0] ADDR_SW_LO   = 7'h01;
  localparam logic [6:0] ADDR_SW_HI   = 7'h02;
  localparam logic [6:0] ADDR_LED_LO  = 7'h03;
  localparam logic [6:0] ADDR_LED_HI  = 7'h04;

  typedef enum logic {
    CMD  = 1'b0,
    DATA = 1'b1
  } state_e;

endpackage

// File: rtl/top_if.sv
// The four SPI wires as seen between an external master and this slave.
interface top_if;
  logic ss_n;
  logic sck;
  logic mosi;
  logic miso;

  modport master (output ss_n, output sck, output mosi, input miso);
  modport slave  (input ss_n, input sck, input mosi, output miso);
endinterface

// File: rtl/top_spi_slave_byte.sv
// Oversampled mode-0 SPI slave byte engine: synchronizers, SCK edge detect,
// bit counter, RX and TX shifters. Everything runs on the system clock.
module spi_slave_byte (
  input  logic       clk,
  input  logic       rst,
  top_if.slave       spi,
  input  logic       tx_load,
  input  logic [7:0] tx_byte,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       ss_idle
);

  logic [1:0] ss_sync;
  logic [1:0] sck_sync;
  logic [1:0] mosi_sync;
  logic       sck_d;
  logic [2:0] bit_cnt;
  logic [6:0] rx_shift;
  logic [7:0] tx_shift;

  wire sck_rise = sck_sync[1] & ~sck_d;
  wire sck_fall = ~sck_sync[1] & sck_d;

  assign ss_idle  = ss_sync[1];
  assign spi.miso = tx_shift[7];

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      ss_sync   <= 2'b11;
      sck_sync  <= 2'b00;
      mosi_sync <= 2'b00;
      sck_d     <= 1'b0;
      bit_cnt   <= 3'd0;
      rx_shift  <= 7'd0;
      tx_shift  <= 8'h00;
      rx_valid  <= 1'b0;
      rx_byte   <= 8'h00;
    end else begin
      ss_sync   <= {ss_sync[0], spi.ss_n};
      sck_sync  <= {sck_sync[0], spi.sck};
      mosi_sync <= {mosi_sync[0], spi.mosi};
      sck_d     <= sck_sync[1];
      rx_valid  <= 1'b0;

      if (ss_sync[1]) begin
        bit_cnt  <= 3'd0;
        rx_shift <= 7'd0;
        tx_shift <= 8'h00;
      end else begin
        if (sck_rise) begin
          rx_shift <= {rx_shift[5:0], mosi_sync[1]};
          bit_cnt  <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            rx_valid <= 1'b1;
            rx_byte  <= {rx_shift, mosi_sync[1]};
          end
        end

        // The falling edge right after a byte's 8th rise must not shift, or
        // the freshly loaded MSB would be lost before the master samples it.
        if (tx_load) begin
          tx_shift <= tx_byte;
        end else if (sck_fall && bit_cnt != 3'd0) begin
          tx_shift <= {tx_shift[6:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: rtl/top.sv
// Board top: SPI slave on Pmod JC giving an external master access to a chip
// ID, the slide switches and a writable LED register.
module top
  import top_pkg::*;
(
  input  logic        CLK100MHZ,
  input  logic        btnC,
  input  logic [15:0] sw,
  output logic [15:0] LED,
  inout  wire  [7:0]  JC
);

  top_if spi ();

  assign spi.ss_n = JC[7];
  assign spi.sck  = JC[6];
  assign spi.mosi = JC[5];
  assign JC[4]    = spi.miso;
  assign JC[3:0]  = 4'bzzzz;

  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       ss_idle;
  logic       tx_load;
  logic [7:0] tx_byte;

  state_e      state;
  logic [6:0]  addr_q;
  logic        rd_q;
  logic [7:0]  led_lo;
  logic [7:0]  led_hi;
  logic [15:0] sw_meta;
  logic [15:0] sw_s;
  logic [7:0]  rd_data;

  spi_slave_byte u_spi (
    .clk      (CLK100MHZ),
    .rst      (btnC),
    .spi      (spi),
    .tx_load  (tx_load),
    .tx_byte  (tx_byte),
    .rx_valid (rx_valid),
    .rx_byte  (rx_byte),
    .ss_idle  (ss_idle)
  );

  // Read data is selected combinationally from the command byte itself so
  // the TX shifter loads one clock after the byte completes.
  // NOTE: every always_comb output gets a default first, so no latch forms.
  always_comb begin
    rd_data = 8'h00;
    case (rx_byte[6:0])
      ADDR_CHIP_ID: rd_data = CHIP_ID;
      ADDR_SW_LO:   rd_data = sw_s[7:0];
      ADDR_SW_HI:   rd_data = sw_s[15:8];
      ADDR_LED_LO:  rd_data = led_lo;
      ADDR_LED_HI:  rd_data = led_hi;
      default:      rd_data = 8'h00;
    endcase
    tx_load = rx_valid;
    tx_byte = (state == CMD && rx_byte[7]) ? rd_data : 8'h00;
  end

  always_ff @(posedge CLK100MHZ) begin
    if (btnC) begin
      state   <= CMD;
      addr_q  <= 7'd0;
      rd_q    <= 1'b0;
      led_lo  <= 8'h00;
      led_hi  <= 8'h00;
      sw_meta <= 16'h0000;
      sw_s    <= 16'h0000;
    end else begin
      sw_meta <= sw;
      sw_s    <= sw_meta;
      if (ss_idle) begin
        state <= CMD;
      end else if (rx_valid) begin
        case (state)
          CMD: begin
            rd_q   <= rx_byte[7];
            addr_q <= rx_byte[6:0];
            state  <= DATA;
          end
          DATA: begin
            if (!rd_q) begin
              case (addr_q)
                ADDR_LED_LO: led_lo <= rx_byte;
                ADDR_LED_HI: led_hi <= rx_byte;
                default: ;
              endcase
            end
            state <= CMD;
          end
          default: state <= CMD;
        endcase
      end
    end
  end

  assign LED = {led_hi, led_lo};

endmodule

// File: tb/tb_top.sv
// Directed bench for the JC SPI register bridge: a bit-banged mode-0 master
// with a scoreboard queue of expected read bytes.
module tb_top;

  localparam int HALF = 6;

  logic        clk = 1'b0;
  logic        btnC;
  logic [15:0] sw;
  wire  [15:0] led;
  wire  [7:0]  jc;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];

  top_if bus ();

  assign jc[7]    = bus.ss_n;
  assign jc[6]    = bus.sck;
  assign jc[5]    = bus.mosi;
  assign bus.miso = jc[4];

  top dut (
    .CLK100MHZ (clk),
    .btnC      (btnC),
    .sw        (sw),
    .LED       (led),
    .JC        (jc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("%s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      bus.mosi = tx[i];
      repeat (HALF) @(negedge clk);
      rx[i] = bus.miso;
      bus.sck = 1'b1;
      repeat (HALF) @(negedge clk);
      bus.sck = 1'b0;
    end
  endtask

  task automatic txn_read(input string tag, input logic [7:0] cmd, input logic [7:0] data,
                          input logic [7:0] exp);
    logic [7:0] r0, r1, e;
    exp_q.push_back(exp);
    spi_byte(cmd, r0);
    check({tag, "_cmdphase"}, {8'h00, r0}, 16'h0000);
    spi_byte(data, r1);
    e = exp_q.pop_front();
    check(tag, {8'h00, r1}, {8'h00, e});
  endtask

  task automatic txn_write(input logic [7:0] cmd, input logic [7:0] data);
    logic [7:0] r0, r1;
    spi_byte(cmd, r0);
    spi_byte(data, r1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    btnC     = 1'b1;
    sw       = 16'h0000;
    bus.ss_n = 1'b1;
    bus.sck  = 1'b0;
    bus.mosi = 1'b0;
    repeat (5) @(negedge clk);
    btnC = 1'b0;
    repeat (5) @(negedge clk);
    check("led_reset", led, 16'h0000);
    check("miso_reset", {15'd0, bus.miso}, 16'h0000);

    bus.ss_n = 1'b0;
    repeat (8) @(negedge clk);
    txn_read("chip_id_1", 8'h80, 8'h00, 8'h07);
    txn_read("chip_id_2", 8'h80, 8'h00, 8'h07);
    txn_read("chip_id_3", 8'h80, 8'h00, 8'h07);

    sw = 16'h00FF;
    repeat (8) @(negedge clk);
    txn_read("sw_lo", 8'h81, 8'h81, 8'hFF);
    txn_read("sw_hi", 8'h82, 8'h82, 8'h00);

    txn_write(8'h03, 8'hFF);
    check("led_write_lo", led, 16'h00FF);
    txn_write(8'h04, 8'hAA);
    check("led_write_hi", led, 16'hAAFF);

    txn_read("led_rd_lo", 8'h83, 8'h83, 8'hFF);
    txn_read("led_rd_hi", 8'h84, 8'h84, 8'hAA);

    txn_write(8'h05, 8'h55);
    check("led_unmapped_wr", led, 16'hAAFF);
    txn_read("unmapped_rd", 8'h85, 8'h85, 8'h00);
    txn_write(8'h00, 8'h33);
    txn_read("chip_id_ro", 8'h80, 8'h00, 8'h07);

    // Abort a write command after 4 bits, then resynchronize with SS_n.
    for (int i = 7; i >= 4; i--) begin
      bus.mosi = (i < 2);
      repeat (HALF) @(negedge clk);
      bus.sck = 1'b1;
      repeat (HALF) @(negedge clk);
      bus.sck = 1'b0;
    end
    bus.ss_n = 1'b1;
    repeat (10) @(negedge clk);
    check("miso_ss_high", {15'd0, bus.miso}, 16'h0000);
    bus.ss_n = 1'b0;
    repeat (10) @(negedge clk);
    check("led_after_abort", led, 16'hAAFF);
    txn_read("resync_rd", 8'h83, 8'h00, 8'hFF);

    txn_write(8'h03, 8'h00);
    txn_write(8'h04, 8'h00);
    check("led_clear", led, 16'h0000);

    check("sb_empty", 16'(exp_q.size()), 16'h0000);

    bus.ss_n = 1'b1;
    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
